// File: rtl/gemm_dot_sequencer_if.sv
// Job handshake plus A/B/C buffer strobe bundle between the GEMM controller and gemm_dot_sequencer.
// The master modport is the sequencer; the slave modport is the job issuer and SRAM/array side.
interface gemm_dot_sequencer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DIM_WIDTH  = 8
);
  logic                  in_valid;
  logic [DIM_WIDTH-1:0]  M_dimension;
  logic [DIM_WIDTH-1:0]  K_dimension;
  logic [DIM_WIDTH-1:0]  N_dimension;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic                  read_enable_A;
  logic                  read_enable_B;
  logic [ADDR_WIDTH-1:0] address_A;
  logic [ADDR_WIDTH-1:0] address_B;
  logic                  start_compute;
  logic                  write_enable_C;
  logic [ADDR_WIDTH-1:0] address_C;

  modport master (
    input  in_valid, M_dimension, K_dimension, N_dimension,
    output busy, done, error, read_enable_A, read_enable_B, address_A, address_B,
           start_compute, write_enable_C, address_C
  );

  modport slave (
    output in_valid, M_dimension, K_dimension, N_dimension,
    input  busy, done, error, read_enable_A, read_enable_B, address_A, address_B,
           start_compute, write_enable_C, address_C
  );
endinterface

// File: rtl/gemm_dot_sequencer.sv
// Walks an MxK by KxN job one dot-product term per cycle and schedules the C writes LAT cycles later.
// Optional busy-cycle counter on perf_cycles when GEMM_SEQ_PERF_EN is defined.
module gemm_dot_sequencer #(
  parameter int ADDR_WIDTH = 16,
  parameter int DIM_WIDTH  = 8,
  parameter int LAT        = 2
) (
  input logic                  clk,
  input logic                  reset_n,
  gemm_dot_sequencer_if.master bus
`ifdef GEMM_SEQ_PERF_EN
  ,
  output logic [31:0]          perf_cycles
`endif
);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_e;

  state_e                state, state_next;
  logic [DIM_WIDTH-1:0]  m_dim, k_dim, n_dim;
  logic [DIM_WIDTH-1:0]  m_cnt, k_cnt, n_cnt;
  logic [ADDR_WIDTH-1:0] addr_a, addr_b, addr_c, a_row;
  logic                  err_flag;
  logic [LAT-1:0]        sr_valid;
  logic [ADDR_WIDTH-1:0] sr_addr [LAT];
  logic                  accept, zero_dim, reading, k_last, n_last, m_last, pending;

  assign accept   = (state == IDLE) && bus.in_valid;
  assign zero_dim = (bus.M_dimension == '0) || (bus.K_dimension == '0) || (bus.N_dimension == '0);
  assign reading  = (state == STREAM);
  assign k_last   = (k_cnt == k_dim - DIM_WIDTH'(1));
  assign n_last   = (n_cnt == n_dim - DIM_WIDTH'(1));
  assign m_last   = (m_cnt == m_dim - DIM_WIDTH'(1));

  // Entries still in flight behind the one currently presented as the C write.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < LAT - 1; i++) pending = pending | sr_valid[i];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: state_next is defaulted first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.in_valid) state_next = zero_dim ? DONE : STREAM;
      STREAM:  if (k_last && n_last && m_last) state_next = DRAIN;
      DRAIN:   if (!pending) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Incremental address walk: A steps by 1 along k, B by N along k; C advances once per dot product.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_dim    <= '0;
      k_dim    <= '0;
      n_dim    <= '0;
      m_cnt    <= '0;
      k_cnt    <= '0;
      n_cnt    <= '0;
      addr_a   <= '0;
      addr_b   <= '0;
      addr_c   <= '0;
      a_row    <= '0;
      err_flag <= 1'b0;
    end else if (accept) begin
      m_dim    <= bus.M_dimension;
      k_dim    <= bus.K_dimension;
      n_dim    <= bus.N_dimension;
      m_cnt    <= '0;
      k_cnt    <= '0;
      n_cnt    <= '0;
      addr_a   <= '0;
      addr_b   <= '0;
      addr_c   <= '0;
      a_row    <= '0;
      err_flag <= zero_dim;
    end else if (reading) begin
      if (!k_last) begin
        k_cnt  <= k_cnt + DIM_WIDTH'(1);
        addr_a <= addr_a + ADDR_WIDTH'(1);
        addr_b <= addr_b + ADDR_WIDTH'(n_dim);
      end else begin
        k_cnt  <= '0;
        addr_c <= addr_c + ADDR_WIDTH'(1);
        if (!n_last) begin
          n_cnt  <= n_cnt + DIM_WIDTH'(1);
          addr_a <= a_row;
          addr_b <= ADDR_WIDTH'(n_cnt) + ADDR_WIDTH'(1);
        end else begin
          n_cnt  <= '0;
          m_cnt  <= m_cnt + DIM_WIDTH'(1);
          a_row  <= a_row + ADDR_WIDTH'(k_dim);
          addr_a <= a_row + ADDR_WIDTH'(k_dim);
          addr_b <= '0;
        end
      end
    end
  end

  // NOTE: the write-tracking shift register is small control state, so it is reset like any flop;
  // a mid-job reset must not leak a stale C write afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_valid <= '0;
      for (int i = 0; i < LAT; i++) sr_addr[i] <= '0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        sr_valid[i] <= sr_valid[i-1];
        sr_addr[i]  <= sr_addr[i-1];
      end
      sr_valid[0] <= reading && k_last;
      sr_addr[0]  <= addr_c;
    end
  end

  assign bus.busy           = (state != IDLE);
  assign bus.done           = (state == DONE);
  assign bus.error          = (state == DONE) && err_flag;
  assign bus.read_enable_A  = reading;
  assign bus.read_enable_B  = reading;
  assign bus.address_A      = reading ? addr_a : '0;
  assign bus.address_B      = reading ? addr_b : '0;
  assign bus.start_compute  = reading && (k_cnt == '0);
  assign bus.write_enable_C = sr_valid[LAT-1];
  assign bus.address_C      = sr_valid[LAT-1] ? sr_addr[LAT-1] : '0;

`ifdef GEMM_SEQ_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           perf_q <= '0;
    else if (accept)        perf_q <= '0;
    else if (state != IDLE) perf_q <= perf_q + 32'd1;
  end

  assign perf_cycles = perf_q;
`endif
endmodule

// File: tb/tb_gemm_dot_sequencer.sv
// Directed self-checking bench for gemm_dot_sequencer with hand-computed read/write schedules.
module tb_gemm_dot_sequencer;
  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int LAT = 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  gemm_dot_sequencer_if #(.ADDR_WIDTH(AW), .DIM_WIDTH(DW)) bus ();
`ifdef GEMM_SEQ_PERF_EN
  logic [31:0] perf_cycles;
`endif

  gemm_dot_sequencer #(.ADDR_WIDTH(AW), .DIM_WIDTH(DW), .LAT(LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef GEMM_SEQ_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int q_a[$], q_b[$], q_sc[$], q_rcyc[$], q_w[$], q_wcyc[$];
  int done_cyc, err_seen, busy_after, done_after, re_bad, busy_gap;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accepts a job on the next edge, then logs every read and write until done (bounded).
  task automatic run_job(input int m, input int k, input int n, input bit poke);
    q_a.delete(); q_b.delete(); q_sc.delete(); q_rcyc.delete(); q_w.delete(); q_wcyc.delete();
    done_cyc = -1; err_seen = 0; re_bad = 0; busy_gap = 0;
    bus.in_valid    = 1'b1;
    bus.M_dimension = DW'(m);
    bus.K_dimension = DW'(k);
    bus.N_dimension = DW'(n);
    step();
    bus.in_valid    = 1'b0;
    bus.M_dimension = 8'd3;
    bus.K_dimension = 8'd0;
    bus.N_dimension = 8'd7;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (bus.read_enable_A !== bus.read_enable_B) re_bad++;
      if (bus.busy !== 1'b1) busy_gap++;
      if (bus.read_enable_A === 1'b1) begin
        q_a.push_back(int'(bus.address_A));
        q_b.push_back(int'(bus.address_B));
        q_sc.push_back(int'(bus.start_compute));
        q_rcyc.push_back(cyc);
      end
      if (bus.write_enable_C === 1'b1) begin
        q_w.push_back(int'(bus.address_C));
        q_wcyc.push_back(cyc);
      end
      if (bus.done === 1'b1) begin
        done_cyc = cyc;
        err_seen = int'(bus.error);
        break;
      end
      bus.in_valid = poke && (cyc == 5);
      step();
    end
    bus.in_valid = 1'b0;
    step();
    busy_after = int'(bus.busy);
    done_after = int'(bus.done);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_error"}, bus.error, 0);
    check({tag, "_re_a"}, bus.read_enable_A, 0);
    check({tag, "_re_b"}, bus.read_enable_B, 0);
    check({tag, "_addr_a"}, bus.address_A, 0);
    check({tag, "_addr_b"}, bus.address_B, 0);
    check({tag, "_sc"}, bus.start_compute, 0);
    check({tag, "_we_c"}, bus.write_enable_C, 0);
    check({tag, "_addr_c"}, bus.address_C, 0);
`ifdef GEMM_SEQ_PERF_EN
    check({tag, "_perf"}, perf_cycles, 0);
`endif
  endtask

  initial begin
    int exp_a[12] = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5};
    int exp_b[12] = '{0, 2, 4, 1, 3, 5, 0, 2, 4, 1, 3, 5};
    int exp_w4[4] = '{5, 8, 11, 14};
    int rd, wr, bz, idx;

    bus.in_valid    = 1'b0;
    bus.M_dimension = '0;
    bus.K_dimension = '0;
    bus.N_dimension = '0;
    #12;
    check_idle_outputs("reset");
    reset_n = 1'b1;
    step();
    step();

    // 1x1x1: read at E+1, write at E+3, done at E+4, busy low at E+5.
    run_job(1, 1, 1, 1'b0);
    check("t1_reads", q_a.size(), 1);
    check("t1_read_cyc", q_rcyc.size() > 0 ? q_rcyc[0] : -1, 1);
    check("t1_addr_a", q_a.size() > 0 ? q_a[0] : -1, 0);
    check("t1_addr_b", q_b.size() > 0 ? q_b[0] : -1, 0);
    check("t1_sc", q_sc.size() > 0 ? q_sc[0] : -1, 1);
    check("t1_writes", q_w.size(), 1);
    check("t1_write_cyc", q_wcyc.size() > 0 ? q_wcyc[0] : -1, 3);
    check("t1_addr_c", q_w.size() > 0 ? q_w[0] : -1, 0);
    check("t1_done_cyc", done_cyc, 4);
    check("t1_error", err_seen, 0);
    check("t1_busy_gap", busy_gap, 0);
    check("t1_busy_after", busy_after, 0);
    check("t1_done_after", done_after, 0);

    // 2x3x2 accepted in the first IDLE cycle after the previous DONE.
    run_job(2, 3, 2, 1'b0);
    check("t2_reads", q_a.size(), 12);
    check("t2_re_ab_equal", re_bad, 0);
    for (int i = 0; i < 12 && i < q_a.size(); i++) begin
      check($sformatf("t2_addr_a[%0d]", i), q_a[i], exp_a[i]);
      check($sformatf("t2_addr_b[%0d]", i), q_b[i], exp_b[i]);
      check($sformatf("t2_sc[%0d]", i), q_sc[i], (i % 3 == 0) ? 1 : 0);
      check($sformatf("t2_rcyc[%0d]", i), q_rcyc[i], i + 1);
    end
    check("t2_writes", q_w.size(), 4);
    for (int i = 0; i < 4 && i < q_w.size(); i++) begin
      check($sformatf("t2_addr_c[%0d]", i), q_w[i], i);
      check($sformatf("t2_wcyc[%0d]", i), q_wcyc[i], exp_w4[i]);
    end
    check("t2_done_cyc", done_cyc, 2 * 3 * 2 + LAT + 1);
    check("t2_busy_after", busy_after, 0);

    // Zero K: no strobes, done and error together one cycle after accept.
    run_job(2, 0, 3, 1'b0);
    check("t3_reads", q_a.size(), 0);
    check("t3_writes", q_w.size(), 0);
    check("t3_done_cyc", done_cyc, 1);
    check("t3_error", err_seen, 1);
    check("t3_busy_after", busy_after, 0);
`ifdef GEMM_SEQ_PERF_EN
    check("t3_perf", perf_cycles, 1);
`endif

    // 4x4x4 with an in_valid pulse while busy that must be ignored.
    run_job(4, 4, 4, 1'b1);
    check("t4_reads", q_a.size(), 64);
    idx = 0;
    for (int m = 0; m < 4; m++)
      for (int n = 0; n < 4; n++)
        for (int k = 0; k < 4; k++) begin
          if (idx < q_a.size()) begin
            check($sformatf("t4_addr_a[%0d]", idx), q_a[idx], m * 4 + k);
            check($sformatf("t4_addr_b[%0d]", idx), q_b[idx], k * 4 + n);
          end
          idx++;
        end
    check("t4_read_span", q_rcyc.size() > 0 ? q_rcyc[q_rcyc.size()-1] - q_rcyc[0] + 1 : -1, 64);
    check("t4_writes", q_w.size(), 16);
    for (int i = 0; i < 16 && i < q_w.size(); i++)
      check($sformatf("t4_addr_c[%0d]", i), q_w[i], i);
    check("t4_done_cyc", done_cyc, 67);
    check("t4_error", err_seen, 0);
    check("t4_busy_after", busy_after, 0);
`ifdef GEMM_SEQ_PERF_EN
    check("t4_perf_done", perf_cycles, 67);
    step(); step(); step();
    check("t4_perf_hold", perf_cycles, 67);
`endif

    // Reset in the middle of a 4x4x4 stream.
    bus.in_valid    = 1'b1;
    bus.M_dimension = 8'd4;
    bus.K_dimension = 8'd4;
    bus.N_dimension = 8'd4;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("t5_streaming", bus.read_enable_A, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle_outputs("t5_async");
    #13;
    reset_n = 1'b1;
    rd = 0; wr = 0; bz = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.read_enable_A === 1'b1) rd++;
      if (bus.write_enable_C === 1'b1) wr++;
      if (bus.busy !== 1'b0) bz++;
    end
    check("t5_reads_after", rd, 0);
    check("t5_writes_after", wr, 0);
    check("t5_busy_after", bz, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
